// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter for a single-port memory with a fixed read delay
// Optional ARB_ROUND_ROBIN_EN: alternate I/D read grants on conflicts instead of fixed D priority.
module mem_arbiter #(
   parameter int READ_DELAY = 10,
   parameter int AW         = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [31:0]   i_rdata,
   output logic          i_done,
   input  logic          d_rd,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic [31:0]   d_rdata,
   output logic          d_done,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   output logic          m_rden,
   output logic          m_wren,
   input  logic [31:0]   m_rdata,
   output logic          busy
);

   localparam logic [7:0] DELAY = 8'(READ_DELAY);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DWRITE = 2'd1,
      READ   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [7:0]    cnt;
   logic [7:0]    cnt_nx;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_nx;
   logic [31:0]   wdata_q;
   logic [31:0]   wdata_nx;
   logic          owner_d;
   logic          owner_d_nx;
   logic          grant_d;
   logic          read_grant;
   logic          capture;

   // A read is granted only from IDLE when no write-back is pending.
   assign read_grant = (state == IDLE) && !d_wr && (d_rd || i_req);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;

   // last_d=0 means I was granted last, so D wins the first conflict after reset.
   assign grant_d = d_rd && !(i_req && last_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d <= 1'b0;
      end else if (read_grant) begin
         last_d <= grant_d;
      end
   end
`else
   assign grant_d = d_rd;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         owner_d <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         owner_d <= owner_d_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_rdata <= 32'd0;
         d_rdata <= 32'd0;
      end else if (capture) begin
         if (owner_d) begin
            d_rdata <= m_rdata;
         end else begin
            i_rdata <= m_rdata;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      addr_nx    = addr_q;
      wdata_nx   = wdata_q;
      owner_d_nx = owner_d;
      m_addr     = '0;
      m_wdata    = 32'd0;
      m_rden     = 1'b0;
      m_wren     = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (d_wr) begin
               addr_nx    = d_addr;
               wdata_nx   = d_wdata;
               owner_d_nx = 1'b1;
               state_nx   = DWRITE;
            end else if (read_grant) begin
               addr_nx    = grant_d ? d_addr : i_addr;
               owner_d_nx = grant_d;
               cnt_nx     = 8'd0;
               state_nx   = READ;
            end
         end
         DWRITE: begin
            m_addr   = addr_q;
            m_wdata  = wdata_q;
            m_wren   = 1'b1;
            state_nx = RESP;
         end
         READ: begin
            m_addr = addr_q;
            cnt_nx = cnt + 8'd1;
            if (cnt == DELAY) begin
               m_rden   = 1'b1;
               capture  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            i_done   = !owner_d;
            d_done   = owner_d;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
   localparam int RD = 10;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [31:0]   i_rdata;
   logic          i_done;
   logic          d_rd = 1'b0;
   logic          d_wr = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [31:0]   d_wdata = 32'd0;
   logic [31:0]   d_rdata;
   logic          d_done;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic          m_rden;
   logic          m_wren;
   logic [31:0]   m_rdata = 32'd0;
   logic          busy;

   always #5 clk = ~clk;

   mem_arbiter #(.READ_DELAY(RD), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rden(m_rden), .m_wren(m_wren),
      .m_rdata(m_rdata), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: one transaction in flight, described by kind, owner, address and grant cycle.
   bit            act, kind_wr, own_d, last_d;
   logic [AW-1:0] t_addr;
   logic [31:0]   t_wdata;
   int            t0;
   logic [31:0]   exp_ir, exp_dr;
   bit            p_idone, p_dwr_done, p_drd_done;
   bit            i_wait, d_wait;

   logic          o_busy, o_rden, o_wren, o_idone, o_ddone;
   logic [AW-1:0] o_addr;
   logic [31:0]   o_wdata, o_ir, o_dr;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic model_reset();
      act = 0; last_d = 0; exp_ir = 32'd0; exp_dr = 32'd0;
      p_idone = 0; p_dwr_done = 0; p_drd_done = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rden"}, m_rden, 0);
      chk({tag, "_wren"}, m_wren, 0);
      chk({tag, "_idone"}, i_done, 0);
      chk({tag, "_ddone"}, d_done, 0);
      chk({tag, "_maddr"}, m_addr, 0);
      chk({tag, "_mwdata"}, m_wdata, 0);
      chk({tag, "_irdata"}, i_rdata, 0);
      chk({tag, "_drdata"}, d_rdata, 0);
   endtask

   // Called right after a falling edge once this cycle's inputs are set.
   task automatic step();
      int off;
      bit e_busy, e_rden, e_wren, e_idone, e_ddone, c_addr;
      logic [AW-1:0] e_addr;
      e_busy = 0; e_rden = 0; e_wren = 0; e_idone = 0; e_ddone = 0; c_addr = 0;
      e_addr = '0;
      #1;
      o_busy = busy; o_rden = m_rden; o_wren = m_wren; o_idone = i_done; o_ddone = d_done;
      o_addr = m_addr; o_wdata = m_wdata; o_ir = i_rdata; o_dr = d_rdata;
      off = cyc - t0;
      if (!act) begin
         c_addr = 1;
      end else if (kind_wr) begin
         e_busy = 1;
         if (off == 1) begin
            e_wren = 1; c_addr = 1; e_addr = t_addr;
         end else begin
            e_ddone = 1;
         end
      end else begin
         e_busy = 1;
         if (off <= RD + 1) begin
            c_addr = 1; e_addr = t_addr; e_rden = (off == RD + 1);
         end else begin
            e_idone = !own_d; e_ddone = own_d;
         end
      end
      chk("busy", o_busy, e_busy);
      chk("m_rden", o_rden, e_rden);
      chk("m_wren", o_wren, e_wren);
      chk("i_done", o_idone, e_idone);
      chk("d_done", o_ddone, e_ddone);
      chk("i_rdata", o_ir, exp_ir);
      chk("d_rdata", o_dr, exp_dr);
      if (c_addr) chk("m_addr", o_addr, e_addr);
      if (e_wren) chk("m_wdata", o_wdata, t_wdata);

      p_idone = e_idone;
      p_dwr_done = e_ddone && kind_wr;
      p_drd_done = e_ddone && !kind_wr;
      if (e_rden) begin
         if (own_d) exp_dr = m_rdata;
         else exp_ir = m_rdata;
      end
      if (e_idone || e_ddone) begin
         act = 0;
      end else if (!act) begin
         if (d_wr) begin
            act = 1; kind_wr = 1; own_d = 1; t_addr = d_addr; t_wdata = d_wdata; t0 = cyc;
         end else if (d_rd || i_req) begin
            act = 1; kind_wr = 0; t0 = cyc;
`ifdef ARB_ROUND_ROBIN_EN
            if (d_rd && i_req) own_d = !last_d;
            else own_d = d_rd;
            last_d = own_d;
`else
            own_d = d_rd;
`endif
            t_addr = own_d ? d_addr : i_addr;
         end
      end
      cyc++;
   endtask

   task automatic apply_dones();
      if (p_idone) begin i_req = 0; i_wait = 0; end
      if (p_dwr_done) d_wr = 0;
      if (p_drd_done) begin d_rd = 0; d_wait = 0; end
   endtask

   task automatic drive_random();
      int sel;
      if (!i_req && !i_wait && $urandom_range(3) == 0) begin
         i_req = 1; i_addr = 16'($urandom);
      end
      if (!d_rd && !d_wr && !d_wait && $urandom_range(3) == 0) begin
         sel = int'($urandom_range(2));
         d_rd = (sel != 1); d_wr = (sel != 0);
         d_addr = 16'($urandom); d_wdata = $urandom;
      end
      if (i_req && act && !kind_wr && !own_d && $urandom_range(7) == 0) begin
         i_req = 0; i_wait = 1;
      end
      if (d_rd && !d_wr && act && !kind_wr && own_d && $urandom_range(7) == 0) begin
         d_rd = 0; d_wait = 1;
      end
      m_rdata = $urandom;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         apply_dones();
         if (!act && !i_req && !d_rd && !d_wr) break;
         step();
      end
      chk("drain_bound", (k < 300), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; i_req = 0; d_rd = 0; d_wr = 0; i_wait = 0; d_wait = 0;
      #1;
      chk_all_zero("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n_wr, n_dd, n_rd, n;
      bit seq [4];
      bit exp_seq [4];
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = '{1, 0, 1, 0};
`else
      exp_seq = '{1, 1, 1, 1};
`endif
      model_reset();
      do_reset();

      // Instruction read with known latency and data.
      @(negedge clk); i_req = 1; i_addr = 16'h0040; m_rdata = 32'hDEADBEEF; step();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk); step();
         if (k == 10) chk("lat_rden_early", o_rden, 0);
         if (k == 11) begin chk("lat_rden", o_rden, 1); chk("lat_addr", o_addr, 32'h0040); end
         if (k == 12) begin chk("lat_idone", o_idone, 1); chk("lat_irdata", o_ir, 32'hDEADBEEF); end
      end
      @(negedge clk); i_req = 0; step();

      // Reset in the middle of a read at counter=5.
      @(negedge clk); i_req = 1; i_addr = 16'h0123; m_rdata = 32'h12345678; step();
      for (int k = 1; k <= 5; k++) begin @(negedge clk); step(); end
      @(negedge clk); rst = 1; i_req = 0;
      #1; chk_all_zero("midrst");
      @(negedge clk); #1; chk_all_zero("midrst_hold");
      @(negedge clk); rst = 0; model_reset();
      for (int k = 0; k < 15; k++) begin @(negedge clk); step(); end

      // Write-back and read together: write first, then the read.
      @(negedge clk);
      d_wr = 1; d_rd = 1; d_addr = 16'h1234; d_wdata = 32'hA5A5A5A5; m_rdata = 32'h0BADF00D;
      step();
      n_wr = 0; n_dd = 0; n_rd = 0;
      for (int k = 1; k <= RD + 8; k++) begin
         @(negedge clk); apply_dones(); step();
         if (k == 1) begin
            chk("wb_wren", o_wren, 1); chk("wb_addr", o_addr, 32'h1234);
            chk("wb_wdata", o_wdata, 32'hA5A5A5A5);
         end
         n_wr += int'(o_wren); n_dd += int'(o_ddone); n_rd += int'(o_rden);
      end
      chk("wb_wren_count", n_wr, 1);
      chk("wb_ddone_count", n_dd, 2);
      chk("wb_rden_count", n_rd, 1);
      chk("wb_drdata", o_dr, 32'h0BADF00D);

      // Data read dropped at counter=3 still completes.
      @(negedge clk); d_rd = 1; d_addr = 16'h0777; m_rdata = 32'hCAFE0001; step();
      n_dd = 0;
      for (int k = 1; k <= RD + 4; k++) begin
         @(negedge clk);
         if (k == 4) d_rd = 0;
         step();
         n_dd += int'(o_ddone);
         if (k == RD + 3) chk("drop_busy_after", o_busy, 0);
      end
      chk("drop_ddone_count", n_dd, 1);

      // Continuous conflict from reset.
      do_reset();
      @(negedge clk); i_req = 1; d_rd = 1; i_addr = 16'h0A0A; d_addr = 16'h0B0B; step();
      n = 0;
      seq = '{0, 0, 0, 0};
      for (int k = 0; k < 200 && n < 4; k++) begin
         @(negedge clk); m_rdata = $urandom; step();
         if (o_idone) begin seq[n] = 0; n++; end
         else if (o_ddone) begin seq[n] = 1; n++; end
      end
      chk("conflict_done_count", n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("conflict_grant%0d", i), seq[i], exp_seq[i]);
      @(negedge clk); i_req = 0; d_rd = 0; step();
      drain();

      // Randomized traffic.
      for (int k = 0; k < 900; k++) begin
         @(negedge clk); apply_dones(); drive_random(); step();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
